// File: rtl/fcfs_queue_arbiter.sv
// rtl/fcfs_queue_arbiter.sv - first-come-first-served arbiter with an arrival-order wait queue
// Optional feature macro: FCFS_TIMEOUT_EN (revoke a holder after HOLD_MAX consecutive grant cycles).
module fcfs_queue_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  localparam int IDW = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int CW  = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   rqst,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic [CW-1:0]  queue_count,
  output logic           timeout_pulse
);

  if (N < 2 || N > 16 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_param
    $error("fcfs_queue_arbiter: N or HOLD_MAX out of range");
  end

  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] hid_q, hid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] q_q [0:N-2];
  logic [IDW-1:0] q_d [0:N-2];

  logic           hv, rel, need, to_c, new_valid;
  logic [IDW-1:0] new_id;
  logic [N-1:0]   queued, arrive;
  logic [CW-1:0]  wn;
  int             skip;

`ifdef FCFS_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       to_q;

  assign to_c = hv && rqst[hid_q] && (hold_q == 8'(HOLD_MAX - 1));

  always_comb begin
    hold_d = 8'd0;
    if (need) hold_d = 8'd0;
    else if (hv) hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= 8'd0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      to_q   <= to_c;
    end
  end

  assign timeout_pulse = to_q;
`else
  assign to_c          = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  // Queue update in one pass: pop the head, compact out withdrawn entries, then append.
  always_comb begin
    hv     = |grant_q;
    rel    = hv && !rqst[hid_q];
    need   = !hv || rel || to_c;
    queued = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (k < int'(cnt_q)) queued[q_q[k]] = 1'b1;
    end
    arrive    = rqst & ~queued & ~grant_q;
    q_d       = '{default: '0};
    wn        = '0;
    skip      = 0;
    new_valid = !need;
    new_id    = need ? '0 : hid_q;
    if (need && cnt_q != '0) begin
      new_valid = 1'b1;
      new_id    = q_q[0];
      skip      = 1;
    end
    for (int k = 0; k < N - 1; k++) begin
      if (k >= skip && k < int'(cnt_q) && rqst[q_q[k]]) begin
        q_d[wn[IDW-1:0]] = q_q[k];
        wn = wn + CW'(1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (arrive[i]) begin
        if (!new_valid) begin
          new_valid = 1'b1;
          new_id    = IDW'(i);
        end else begin
          q_d[wn[IDW-1:0]] = IDW'(i);
          wn = wn + CW'(1);
        end
      end
    end
    // A timed-out holder goes behind this edge's arrivals, or is re-granted if nobody waits.
    if (to_c) begin
      if (!new_valid) begin
        new_valid = 1'b1;
        new_id    = hid_q;
      end else begin
        q_d[wn[IDW-1:0]] = hid_q;
        wn = wn + CW'(1);
      end
    end
    grant_d = new_valid ? (N'(1) << new_id) : '0;
    hid_d   = new_valid ? new_id : '0;
    cnt_d   = wn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      hid_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '{default: '0};
    end else begin
      grant_q <= grant_d;
      hid_q   <= hid_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = hid_q;
  assign queue_count = cnt_q;

endmodule

// File: tb/tb_fcfs_queue_arbiter.sv
// tb/tb_fcfs_queue_arbiter.sv - self-checking bench for fcfs_queue_arbiter (N=4, HOLD_MAX=8)
module tb_fcfs_queue_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rqst = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [2:0] queue_count;
  logic       timeout_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fcfs_queue_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .rqst         (rqst),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .queue_count  (queue_count),
    .timeout_pulse(timeout_pulse)
  );

  // Reference model: holder index (-1 idle), waiting list in arrival order, cycles held.
  int m_holder = -1;
  int m_q[$];
  int m_hold = 0;
  bit m_pulse = 1'b0;

  function automatic void model_reset();
    m_holder = -1;
    m_q.delete();
    m_hold  = 0;
    m_pulse = 1'b0;
  endfunction

  function automatic bit in_queue(input int idx);
    foreach (m_q[k]) if (m_q[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    int arr[$];
    int kept[$];
    int nh;
    bit rel, to, need;
    rel = (m_holder >= 0) && !r[m_holder];
    to  = 1'b0;
`ifdef FCFS_TIMEOUT_EN
    to = (m_holder >= 0) && r[m_holder] && (m_hold + 1 == HOLD_MAX);
`endif
    need = (m_holder < 0) || rel || to;
    for (int i = 0; i < N; i++)
      if (r[i] && i != m_holder && !in_queue(i)) arr.push_back(i);
    nh = need ? -1 : m_holder;
    if (need && m_q.size() > 0) nh = m_q.pop_front();
    foreach (m_q[k]) if (r[m_q[k]]) kept.push_back(m_q[k]);
    m_q = kept;
    foreach (arr[k]) begin
      if (nh < 0) nh = arr[k];
      else m_q.push_back(arr[k]);
    end
    m_pulse = to;
    if (to) begin
      if (nh < 0) nh = m_holder;
      else m_q.push_back(m_holder);
    end
    m_hold   = need ? 0 : m_hold + 1;
    m_holder = nh;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_grant_id", 32'(grant_id), (m_holder >= 0) ? 32'(m_holder) : 32'd0);
    chk("model_grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
    chk("model_queue_count", 32'(queue_count), 32'(m_q.size()));
    chk("model_timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    chk("onehot_grant", 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    rqst = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    int         qc;
  } vec_t;

  vec_t tbl[25];

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 0};
    tbl[1]  = '{4'b0100, 4'b0100, 0};
    tbl[2]  = '{4'b0000, 4'b0000, 0};
    tbl[3]  = '{4'b1111, 4'b0001, 3};
    tbl[4]  = '{4'b1110, 4'b0010, 2};
    tbl[5]  = '{4'b1100, 4'b0100, 1};
    tbl[6]  = '{4'b1000, 4'b1000, 0};
    tbl[7]  = '{4'b0000, 4'b0000, 0};
    tbl[8]  = '{4'b0001, 4'b0001, 0};
    tbl[9]  = '{4'b1001, 4'b0001, 1};
    tbl[10] = '{4'b1001, 4'b0001, 1};
    tbl[11] = '{4'b1011, 4'b0001, 2};
    tbl[12] = '{4'b1010, 4'b1000, 1};
    tbl[13] = '{4'b0010, 4'b0010, 0};
    tbl[14] = '{4'b0000, 4'b0000, 0};
    tbl[15] = '{4'b0100, 4'b0100, 0};
    tbl[16] = '{4'b0110, 4'b0100, 1};
    tbl[17] = '{4'b1110, 4'b0100, 2};
    tbl[18] = '{4'b1100, 4'b0100, 1};
    tbl[19] = '{4'b1000, 4'b1000, 0};
    tbl[20] = '{4'b0000, 4'b0000, 0};
    tbl[21] = '{4'b0111, 4'b0001, 2};
    tbl[22] = '{4'b0100, 4'b0010, 1};
    tbl[23] = '{4'b0100, 4'b0100, 0};
    tbl[24] = '{4'b0000, 4'b0000, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_grant_valid", 32'(grant_valid), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_queue_count", 32'(queue_count), 32'd0);
    chk("reset_timeout_pulse", 32'(timeout_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].r);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_queue_count", i), 32'(queue_count), 32'(tbl[i].qc));
      check_model();
    end

    // Holder 0 kept high with requester 1 waiting: timeout handover or indefinite hold.
    step(4'b0011);
    chk("hold_first_grant", 32'(grant), 32'(4'b0001));
    for (int i = 0; i < 7; i++) begin
      step(4'b0011);
      chk($sformatf("hold_cycle%0d_grant", i), 32'(grant), 32'(4'b0001));
      chk($sformatf("hold_cycle%0d_pulse", i), 32'(timeout_pulse), 32'd0);
    end
    step(4'b0011);
`ifdef FCFS_TIMEOUT_EN
    chk("timeout_grant", 32'(grant), 32'(4'b0010));
    chk("timeout_pulse_high", 32'(timeout_pulse), 32'd1);
`else
    chk("no_timeout_grant", 32'(grant), 32'(4'b0001));
    chk("no_timeout_pulse", 32'(timeout_pulse), 32'd0);
`endif
    chk("timeout_queue_count", 32'(queue_count), 32'd1);
    check_model();
    step(4'b0011);
    chk("pulse_one_cycle", 32'(timeout_pulse), 32'd0);
    check_model();
    step(4'b0000);
    check_model();

    // Asynchronous reset mid-grant with two waiters.
    step(4'b0111);
    chk("pre_reset_queue_count", 32'(queue_count), 32'd2);
    reset = 1'b1;
    #1;
    chk("async_reset_grant", 32'(grant), 32'd0);
    chk("async_reset_grant_valid", 32'(grant_valid), 32'd0);
    chk("async_reset_grant_id", 32'(grant_id), 32'd0);
    chk("async_reset_queue_count", 32'(queue_count), 32'd0);
    chk("async_reset_timeout_pulse", 32'(timeout_pulse), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(4'b0110);
    chk("post_reset_grant", 32'(grant), 32'(4'b0010));
    chk("post_reset_queue_count", 32'(queue_count), 32'd1);
    check_model();

    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      r = rqst;
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      step(r);
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcfs_queue_arbiter.md
FCFS_QUEUE_ARBITER -- requirements
Module: fcfs_queue_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, legal range 2..16.
REQ-002 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles, used only with FCFS_TIMEOUT_EN, legal range 1..255.
REQ-003 Derived IDW = max(1, clog2(N)); CW = clog2(N+1).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rqst  in  N  level request per requester; bit i = requester i.
REQ-007 grant  out  N  registered one-hot grant, all-zero when idle.
REQ-008 grant_valid  out  1  high when any grant bit is high.
REQ-009 grant_id  out  IDW  index of the current holder, 0 when idle.
REQ-010 queue_count  out  CW  number of waiting (queued, not granted) requesters.
REQ-011 timeout_pulse  out  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-012 The block SHALL keep an arrival-order queue of requester indices, depth N-1, holding waiting requesters only; the holder is never queued.
REQ-013 Arrival: at an edge, requester i SHALL count as arriving if rqst[i]=1, it is not queued, and it is not the holder.
REQ-014 Same-edge arrivals SHALL be appended to the queue tail in ascending index order.
REQ-015 Idle arbiter, empty queue: the lowest-index arrival SHALL be granted at that edge (grant high the next cycle, 1-cycle latency); the remaining arrivals are queued.
REQ-016 Idle arbiter, non-empty queue: the queue head SHALL be granted and popped at that edge, ahead of any new arrivals.
REQ-017 Holder release: if rqst[holder]=0 at an edge, the grant SHALL be removed at that edge and the queue head (or the lowest-index arrival if the queue is empty) SHALL be granted at the same edge, with no idle cycle.
REQ-018 Withdrawal: a queued requester sampled with rqst=0 SHALL be purged at that edge; the relative order of the remaining entries is preserved.
REQ-019 Pop, purge and append at one edge SHALL all take effect, in the order pop, purge, append.
REQ-020 grant SHALL have at most one bit set in every cycle; grant_id and grant_valid SHALL be consistent with grant.
REQ-021 A requester held high SHALL keep its grant indefinitely unless FCFS_TIMEOUT_EN applies.
REQ-022 queue_count SHALL reflect the registered queue occupancy and never exceed N-1.

Reset
REQ-023 While reset=1: grant=0, grant_valid=0, grant_id=0, queue_count=0, timeout_pulse=0, queue empty, hold counter=0.
REQ-024 Reset asserted mid-grant SHALL clear all state immediately (asynchronously).
REQ-025 The first edge after reset deasserts SHALL evaluate arrivals per REQ-013..REQ-015.

Configuration
REQ-026 Macro FCFS_TIMEOUT_EN defined: an 8-bit hold counter SHALL count consecutive grant cycles of the current holder, resetting on every new grant.
REQ-027 With FCFS_TIMEOUT_EN, on the edge where the holder completes HOLD_MAX grant cycles while still requesting, the block SHALL:
 - revoke the holder;
 - grant the queue head (or re-grant the same holder if the queue is empty and there are no new arrivals);
 - append the revoked holder at the tail, after same-edge arrivals;
 - pulse timeout_pulse for 1 cycle.
REQ-028 Macro FCFS_TIMEOUT_EN undefined: no hold counter; timeout_pulse SHALL be tied 0; HOLD_MAX is ignored.

Verification (N=4, HOLD_MAX=8)
REQ-029 rqst=0000 then 0100 at edge k -> grant=0100, grant_id=2 from cycle k+1; queue_count=0.
REQ-030 Holder 0 active; rqst[3] rises at edge k, then rqst[1] rises at k+2; rqst[0] drops at k+5 -> grant=1000 from k+6; rqst[3] drops -> grant=0010; no idle cycle at either handover.
REQ-031 Idle, rqst=1111 at one edge -> grant order 0,1,2,3 as each holder drops; queue_count goes 3,2,1,0.
REQ-032 Holder 2 with 1 and 3 queued (1 first); rqst[1] drops -> queue_count 2->1; on holder release grant=1000.
REQ-033 FCFS_TIMEOUT_EN, holder 0 held high, 1 queued -> after 8 grant cycles grant=0010, timeout_pulse=1 for one cycle, 0 re-queued, queue_count=1; without the macro grant stays 0001.
REQ-034 reset asserted mid-grant with queue_count=2 -> all outputs are 0 before the next clock edge; after release, the lowest-index active request is granted at the first edge.
